// File: rtl/btn_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer (hold FSM states, counter sizing).
// Hold logic is only built when DEBOUNCE_REPEAT_EN is defined.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REPEAT
  } hold_state_e;

  localparam logic ST_IDLE_LEVEL = 1'b0;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF sync, consecutive-stability debounce, registered press/release strobes.
// Level lags the pin by 2+DELAY cycles; optional hold/auto-repeat strobe under DEBOUNCE_REPEAT_EN.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DELAY      = 4,
  parameter bit ACTIVE_LOW = 1'b0
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int HOLD_DELAY    = 10,
  parameter int REPEAT_PERIOD = 3
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_btn_db,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int CW = cnt_width(DELAY, 0);
  localparam logic [CW-1:0] DLY_LAST = CW'(DELAY - 1);

  logic          x;
  logic          sync1_q, s_q;
  logic          st_q, st_d, st_dly_q;
  logic          press_q, release_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign x = i_btn ^ ACTIVE_LOW;

  // Any agreeing cycle clears the count, so st only moves after DELAY straight disagreements.
  always_comb begin
    st_d  = st_q;
    cnt_d = '0;
    if (s_q != st_q) begin
      if (cnt_q == DLY_LAST) st_d = s_q;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q   <= ST_IDLE_LEVEL;
      s_q       <= ST_IDLE_LEVEL;
      st_q      <= ST_IDLE_LEVEL;
      st_dly_q  <= ST_IDLE_LEVEL;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= x;
      s_q       <= sync1_q;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      st_dly_q  <= st_q;
      press_q   <= st_q & ~st_dly_q;
      release_q <= ~st_q & st_dly_q;
    end
  end

  assign o_btn_db  = st_q;
  assign o_press   = press_q;
  assign o_release = release_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int HW = cnt_width(HOLD_DELAY, REPEAT_PERIOD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_DELAY - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_PERIOD - 1);

  hold_state_e   hst_q;
  logic [HW-1:0] hcnt_q;
  logic          hold_q;

  // Leaving on st_d (not st_q) keeps a hold pulse from landing in the cycle st falls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hst_q  <= IDLE;
      hcnt_q <= '0;
      hold_q <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      case (hst_q)
        IDLE: begin
          if (st_q & ~st_dly_q) begin
            hst_q  <= WAIT;
            hcnt_q <= '0;
          end
        end
        WAIT, REPEAT: begin
          if (!st_d) begin
            hst_q  <= IDLE;
            hcnt_q <= '0;
          end else if (hcnt_q == ((hst_q == WAIT) ? HOLD_LAST : REP_LAST)) begin
            hold_q <= 1'b1;
            hcnt_q <= '0;
            hst_q  <= REPEAT;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        default: begin
          hst_q  <= IDLE;
          hcnt_q <= '0;
        end
      endcase
    end
  end

  assign o_hold = hold_q;
`else
  assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_array.sv
// N_CH independent debounced buttons with press/release strobes; all outputs registered.
// Hold/auto-repeat strobes exist only when DEBOUNCE_REPEAT_EN is defined, otherwise o_hold is 0.
module btn_debounce_array
  import btn_debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DELAY         = 1_000_000,
  parameter int ACTIVE_LOW    = 0,
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_btn_db,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_hold
);

  if (N_CH < 1 || N_CH > 32 || DELAY < 2 || HOLD_DELAY <= DELAY || REPEAT_PERIOD < 2) begin : g_bad_cfg
    $error("btn_debounce_array: illegal parameter combination");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .DELAY        (DELAY),
      .ACTIVE_LOW   (ACTIVE_LOW != 0)
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .HOLD_DELAY   (HOLD_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_btn    (i_btn[g]),
      .o_btn_db (o_btn_db[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_hold   (o_hold[g])
    );
  end

endmodule
